// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: aligns store data into byte lanes, waits for the data memory,
// and returns sign/zero-extended load data to write-back while stalling the pipeline.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_sel,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [3:0]  byte_en,
  inout  wire  [31:0] dmem_data,
  input  logic        dmem_ready,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_sel,
  output logic [31:0] wb_val,
  output logic [1:0]  lsu_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e           state_q;
  logic             wr_q;
  logic [2:0]       fn3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [4:0]       rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             wb_valid_q;
  logic [4:0]       wb_rd_q;
  logic [31:0]      wb_val_q;
  logic [1:0]       err_q;

  logic             req_illegal;
  logic             req_misaligned;
  logic             accept;
  logic [31:0]      store_data;
  logic [31:0]      load_shift;
  logic [31:0]      load_ext;

  always_comb begin
    req_illegal = req_wr ? (req_fn3 > 3'd2) : (req_fn3 == 3'd3 || req_fn3[2:1] == 2'b11);
    case (req_fn3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign accept    = (state_q == StIdle) && req_valid && !req_illegal && !req_misaligned;
  assign lsu_stall = (state_q == StBusy) || accept;

  // Memory-side outputs decode from registered state only, so reset releases them at once.
  always_comb begin
    dmem_addr = '0;
    byte_en   = '0;
    dmem_wen  = 1'b0;
    if (state_q == StBusy) begin
      dmem_addr = {addr_q[31:2], 2'b00};
      dmem_wen  = wr_q;
      case (fn3_q[1:0])
        2'b00:   byte_en = 4'b0001 << addr_q[1:0];
        2'b01:   byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        default: byte_en = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (fn3_q[1:0])
      2'b00:   store_data = {4{wdata_q[7:0]}};
      2'b01:   store_data = {2{wdata_q[15:0]}};
      default: store_data = wdata_q;
    endcase
  end

  assign dmem_data = (state_q == StBusy && wr_q) ? store_data : 'z;

  always_comb begin
    load_shift = dmem_data >> {addr_q[1:0], 3'b000};
    case (fn3_q)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_ext = {24'b0, load_shift[7:0]};
      3'b101:  load_ext = {16'b0, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_q       <= 1'b0;
      fn3_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_val_q   <= '0;
      err_q      <= 2'b00;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_illegal) begin
              err_q <= 2'b10;
            end else if (req_misaligned) begin
              err_q <= 2'b01;
            end else begin
              wr_q    <= req_wr;
              fn3_q   <= req_fn3;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              rd_q    <= req_rd_sel;
              cnt_q   <= '0;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (dmem_ready) begin
            state_q <= StResp;
            if (!wr_q) begin
              wb_valid_q <= 1'b1;
              wb_val_q   <= load_ext;
              wb_rd_q    <= rd_q;
            end
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q <= StResp;
            err_q   <= 2'b11;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_rd_sel = wb_rd_q;
  assign wb_val    = wb_val_q;
  assign lsu_err   = err_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline, between the EX/MEM pipeline register and the external data memory port. It takes one decoded load or store per transaction and aligns store data into byte lanes with matching byte enables. It waits a variable number of cycles for memory, then returns sign- or zero-extended load data to write-back. While a transaction is outstanding it asserts a stall that freezes the upstream pipeline.

## Interface
- TIMEOUT, 16: maximum BUSY cycles to wait for `dmem_ready` before aborting; must be ≥2.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  memory operation present from EX/MEM; held stable while `lsu_stall`=1.
- req_wr  in  1  1=store, 0=load.
- req_fn3  in  3  RV32I funct3: loads LB=000 LH=001 LW=010 LBU=100 LHU=101; stores SB=000 SH=001 SW=010.
- req_addr  in  32  effective byte address (ALU result).
- req_wdata  in  32  store source (rs2 value), low bits used.
- req_rd_sel  in  5  load destination register.
- dmem_addr  out  32  word address to memory, {addr[31:2],2'b00}.
- dmem_wen  out  1  memory write enable.
- byte_en  out  4  active byte lanes, bit i = bits 8i+7:8i.
- dmem_data  inout  32  memory data bus, driven only during a store.
- dmem_ready  in  1  memory ack: write done, or read data valid this cycle.
- lsu_stall  out  1  upstream must hold.
- wb_valid  out  1  one-cycle pulse: `wb_val`/`wb_rd_sel` valid for register write.
- wb_rd_sel  out  5  destination register for `wb_val`.
- wb_val  out  32  extended load result.
- lsu_err  out  2  one-cycle error pulse: 00 none, 01 misaligned, 10 illegal funct3, 11 timeout.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE with `req_valid`=1 and request legal and aligned:
  - capture wr, fn3, addr, wdata, rd_sel;
  - clear wait counter;
  - go to BUSY.
- IDLE with `req_valid`=1 and request illegal or misaligned:
  - request is dropped; no state change; no memory access;
  - `lsu_err` pulses next cycle, 10 takes priority over 01.
- Illegal funct3: loads 011/110/111; stores ≥011.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- BUSY:
  - drive `dmem_addr` and `byte_en`;
  - stores drive `dmem_wen`=1 and `dmem_data`;
  - if `dmem_ready`=1, go to RESP; loads capture the extended data;
  - otherwise increment the counter; if the counter equals TIMEOUT-1, abort to RESP with `lsu_err`=11 pulsed and no write-back.
- RESP: one cycle; `wb_valid`=1 only for a completed load; `req_valid` is ignored (it is the finished request); go to IDLE.
- `byte_en` per access size:
  - byte: 4'b0001<<addr[1:0];
  - half: addr[1] ? 1100 : 0011;
  - word: 1111.
- Loads use the same `byte_en`, with `dmem_wen`=0.
- Store data on `dmem_data`: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extraction: select the lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- `lsu_stall` = (state==BUSY) | (state==IDLE & req_valid & legal & aligned), combinational.
- `dmem_data` is high-Z whenever the block is not in BUSY on a store.

## Timing
- All outputs are 0 in reset, and `dmem_data` is high-Z; state is IDLE and the counter is 0.
- Assertion of `rst_n` is asynchronous, so `dmem_wen` drops and `dmem_data` releases immediately, including mid-BUSY; an in-flight access is discarded with no `wb_valid` and no `lsu_err`.
- Zero-wait memory (`dmem_ready`=1 in the first BUSY cycle):
  - accept at cycle 0;
  - BUSY at cycle 1;
  - RESP (`wb_valid`) at cycle 2;
  - `lsu_stall` is high in cycles 0–1 and low in cycle 2.
- Each memory wait cycle adds one BUSY cycle.
- A new request can be accepted in the cycle after RESP; the minimum issue interval is 3 cycles.
- Memory-side outputs (`dmem_addr`, `byte_en`, `dmem_wen`) are 0 outside BUSY.
- `dmem_ready` is sampled only in BUSY and ignored in IDLE and RESP.
- `wb_val`, `wb_rd_sel` and `lsu_err` are registered; `wb_val` and `wb_rd_sel` hold their last value when `wb_valid`=0.
- Timeout: with `dmem_ready` stuck low, RESP follows exactly TIMEOUT BUSY cycles.
- An error pulse is never coincident with `wb_valid`=1.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with zero wait, rd=5 -> `lsu_stall` high 2 cycles, `dmem_addr`=0x100, `byte_en`=1111, `wb_valid` at cycle 2 with `wb_val`=0xDEADBEEF, `wb_rd_sel`=5.
- LB and LBU at 0x103, memory word 0x80123456, 3 wait cycles -> `byte_en`=1000; LB gives `wb_val`=0xFFFFFF80, LBU gives 0x00000080; `wb_valid` at cycle 5.
- SH at 0x102 with `req_wdata`=0x1234ABCD -> in BUSY `dmem_wen`=1, `byte_en`=1100, `dmem_data`=0xABCDABCD; `wb_valid` stays 0; bus high-Z afterward.
- LW at 0x105 -> no stall, no memory access, `lsu_err`=01 for one cycle; a load with fn3=011 gives `lsu_err`=10.
- TIMEOUT=16, `dmem_ready` held low -> 16 BUSY cycles, then `lsu_err`=11, `wb_valid`=0, FSM returns to IDLE.
- `rst_n` low during BUSY of an SW -> `dmem_wen`=0 and `dmem_data` high-Z in the same cycle; after release, an LW completes normally.
